// File: rtl/id_queue_oup_arb.sv
// Round-robin arbiter sharing one id_queue lookup/pop port between NumReq requesters.
// The winner is locked while the queue withholds its grant, so the downstream request stays stable.
module id_queue_oup_arb #(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned IdWidth = 10,
    parameter type         data_t  = logic [3:0]
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq-1:0][IdWidth-1:0] id_i,
    input  logic [NumReq-1:0]              pop_i,
    output logic [NumReq-1:0]              gnt_o,
    output data_t                          data_o,
    output logic [NumReq-1:0]              data_valid_o,
    output logic                           oup_req_o,
    output logic [IdWidth-1:0]             oup_id_o,
    output logic                           oup_pop_o,
    input  logic                           oup_gnt_i,
    input  data_t                          oup_data_i,
    input  logic                           oup_data_valid_i
);
    localparam int unsigned SelW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e          state_q, state_d;
    logic [SelW-1:0] rr_q, rr_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [SelW-1:0] win;
    logic [SelW-1:0] cand;
    logic [SelW:0]   scan;
    logic            found;

    // Winner: locked index, else first requester at or after rr_q (scan carries one extra bit for the wrap).
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        cand  = '0;
        if (state_q == LOCKED) begin
            found = 1'b1;
            win   = sel_q;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                scan = {1'b0, rr_q} + (SelW+1)'(k);
                if (scan >= (SelW+1)'(NumReq)) begin
                    scan = scan - (SelW+1)'(NumReq);
                end
                cand = scan[SelW-1:0];
                if (!found && req_i[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
        if (rst_i) begin
            found = 1'b0;
        end
    end

    always_comb begin
        gnt_o        = '0;
        data_valid_o = '0;
        oup_req_o    = found;
        oup_id_o     = '0;
        oup_pop_o    = 1'b0;
        if (found) begin
            oup_id_o           = id_i[win];
            oup_pop_o          = pop_i[win];
            gnt_o[win]         = oup_gnt_i;
            data_valid_o[win]  = oup_gnt_i & oup_data_valid_i;
        end
    end

    assign data_o = oup_data_i;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        if (found) begin
            if (oup_gnt_i) begin
                state_d = IDLE;
                rr_d    = (win == SelW'(NumReq-1)) ? '0 : win + SelW'(1);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                sel_d   = win;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
        end
    end
endmodule

// File: tb/tb_id_queue_oup_arb.sv
// Bench for id_queue_oup_arb: a behavioural id_queue answers the arbiter's port, and a
// reference arbiter model pushes expected outputs to a scoreboard popped after the DUT settles.
module tb_id_queue_oup_arb;
    localparam int N   = 4;
    localparam int W   = 10;
    localparam int CAP = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req, pop, gnt, dval;
    logic [N-1:0][W-1:0] id;
    logic [3:0]          data, odata;
    logic                oreq, opop, ogt, odv;
    logic [W-1:0]        oid;
    logic                stall;

    always #5 clk = ~clk;

    id_queue_oup_arb #(.NumReq(N), .IdWidth(W), .data_t(logic [3:0])) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .id_i(id), .pop_i(pop),
        .gnt_o(gnt), .data_o(data), .data_valid_o(dval),
        .oup_req_o(oreq), .oup_id_o(oid), .oup_pop_o(opop),
        .oup_gnt_i(ogt), .oup_data_i(odata), .oup_data_valid_i(odv)
    );

    typedef struct packed {
        logic         oreq;
        logic [W-1:0] oid;
        logic         opop;
        logic [N-1:0] gnt;
        logic [N-1:0] dval;
        logic [3:0]   data;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    // queue model: entries kept oldest-first
    logic [W-1:0] qid[CAP];
    logic [3:0]   qdat[CAP];
    int           qcnt = 0;

    // reference arbiter state
    int m_rr = 0, m_lock = 0, m_sel = 0;
    logic [N-1:0] last_gnt = '0;
    int grants = 0;
    int waiting[N];

    function automatic int lookup(input logic [W-1:0] k);
        for (int i = 0; i < qcnt; i++) if (qid[i] == k) return i;
        return -1;
    endfunction

    task automatic push_q(input logic [W-1:0] k, input logic [3:0] d);
        if (qcnt < CAP) begin
            qid[qcnt]  = k;
            qdat[qcnt] = d;
            qcnt++;
        end
    endtask

    task automatic remove_q(input int idx);
        for (int i = idx; i < qcnt - 1; i++) begin
            qid[i]  = qid[i+1];
            qdat[i] = qdat[i+1];
        end
        qcnt--;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input int want_g = -1, input int want_dv = -1);
        exp_t e;
        int   w, qi, qj, k;
        bit   hs;
        #1;
        w = -1;
        if (!rst) begin
            if (m_lock != 0) w = m_sel;
            else begin
                k = 0;
                while (w < 0 && k < N) begin
                    if (req[(m_rr + k) % N]) w = (m_rr + k) % N;
                    k++;
                end
            end
        end
        e  = '0;
        qi = -1;
        if (w >= 0) begin
            e.oreq = 1'b1;
            e.oid  = id[w];
            e.opop = pop[w];
            qi     = lookup(id[w]);
        end
        hs = (w >= 0) && !stall;
        if (hs) begin
            e.gnt[w] = 1'b1;
            if (qi >= 0) e.dval[w] = 1'b1;
        end
        e.data = (qi >= 0) ? qdat[qi] : 4'h0;
        sb.push_back(e);

        qj    = lookup(oid);
        ogt   = oreq & ~stall;
        odv   = (qj >= 0);
        odata = (qj >= 0) ? qdat[qj] : 4'h0;
        #1;

        e = sb.pop_front();
        chk("oup_req", 32'(oreq), 32'(e.oreq));
        chk("oup_id", 32'(oid), 32'(e.oid));
        chk("oup_pop", 32'(opop), 32'(e.opop));
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("data_valid", 32'(dval), 32'(e.dval));
        chk("data", 32'(data), 32'(e.data));
        if (want_g >= 0) chk("gnt_directed", 32'(gnt), want_g);
        if (want_dv >= 0) chk("dval_directed", 32'(dval), want_dv);

        if (rst) begin
            m_rr = 0; m_lock = 0; m_sel = 0;
        end else if (w >= 0) begin
            if (hs) begin
                m_lock = 0;
                m_rr   = (w + 1) % N;
                if (e.opop && qi >= 0) remove_q(qi);
            end else begin
                m_lock = 1;
                m_sel  = w;
            end
        end
        last_gnt = e.gnt;
        if (|e.gnt) grants++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '1; pop = '1; id = '0; stall = 1'b0;
        ogt = 1'b0; odv = 1'b0; odata = '0;
        for (int r = 0; r < N; r++) waiting[r] = 0;
        @(negedge clk);
        step(0, 0);
        step(0, 0);

        // round-robin order with four A entries under ID 0x005
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push_q(W'(10'h005), 4'hA);
        for (int r = 0; r < N; r++) id[r] = W'(10'h005);
        step(1, 1);
        step(2, 2);
        step(4, 4);
        step(8, 8);
        step(1, 0);

        // wrap-around: 3 first, then only 0 and 2
        pop = '0;
        req = 4'b1000; step(8);
        req = 4'b0101; step(1); step(4); step(1); step(4);

        // lock under stall: 1 holds the port while 0 arrives with higher priority
        req = 4'b0010; id[1] = W'(10'h012); stall = 1'b1;
        step(0); step(0);
        req = 4'b0011; id[0] = W'(10'h001);
        step(0);
        stall = 1'b0; step(2);
        req = 4'b0001; step(1);

        // read versus pop on ID 0x3FF
        push_q(W'(10'h3FF), 4'h7);
        req = 4'b0100; id[2] = W'(10'h3FF); pop[2] = 1'b0;
        step(4, 4);
        pop[2] = 1'b1; step(4, 4);
        pop[2] = 1'b0; step(4, 0);

        // reset while locked on requester 3
        req = 4'b1000; id[3] = W'(10'h020); stall = 1'b1;
        step(0); step(0);
        rst = 1'b1; step(0, 0);
        rst = 1'b0; stall = 1'b0; req = 4'b1001; step(1);

        // random soak
        req = '0; pop = '0; last_gnt = '0; grants = 0;
        for (int cyc = 0; cyc < 40000 && grants < 10000; cyc++) begin
            stall = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) push_q(W'($urandom_range(3, 1)), 4'($urandom));
            for (int r = 0; r < N; r++) begin
                if (!(req[r] && !last_gnt[r])) begin
                    req[r] = ($urandom_range(2) != 0);
                    id[r]  = W'($urandom_range(3, 1));
                    pop[r] = 1'($urandom_range(1));
                end
            end
            step();
            for (int r = 0; r < N; r++) begin
                if (req[r] && last_gnt[r]) begin
                    chk("starvation", 32'(waiting[r] < N), 32'd1);
                    waiting[r] = 0;
                end else if (req[r] && (|last_gnt)) begin
                    waiting[r]++;
                end
            end
        end
        chk("soak_grants", 32'(grants >= 10000), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_queue_oup_arb.md
# id_queue_oup_arb

Round-robin arbiter that shares the single output port (lookup/pop) of an `id_queue` instance between `NumReq` requesters. It sits between the requesters and the queue's `oup_*` port and forwards the selected requester's ID and pop flag. It routes the queue's data and valid response back to the granted requester only. Selection is fair, and it is held stable while the queue withholds its grant, so the downstream request never changes before it is granted.

## Interface
- `NumReq`, default 4: number of requesters, at least 2.
- `IdWidth`, default 10: width of the queue ID. Must match the connected `id_queue` `ID_WIDTH`.
- `data_t`, default `logic[3:0]`: queue data type. Must match the connected `id_queue`.
- `clk_i`  in  1: clock. All state changes on the rising edge.
- `rst_i`  in  1: reset. Synchronous, active-high.
- `req_i`  in  NumReq: per-requester request.
- `id_i`  in  NumReq×IdWidth: per-requester ID to read or pop.
- `pop_i`  in  NumReq: per-requester pop flag. 1 removes the entry; 0 only reads it.
- `gnt_o`  out  NumReq: per-requester grant, one-hot or zero.
- `data_o`  out  $bits(data_t): data of the queue head for the granted ID. Common to all requesters.
- `data_valid_o`  out  NumReq: per-requester data valid. Asserted only together with that requester's `gnt_o`.
- `oup_req_o`  out  1: request to the queue.
- `oup_id_o`  out  IdWidth: ID sent to the queue.
- `oup_pop_o`  out  1: pop flag sent to the queue.
- `oup_gnt_i`  in  1: grant from the queue. Combinational in the same cycle.
- `oup_data_i`  in  $bits(data_t): data from the queue.
- `oup_data_valid_i`  in  1: data valid from the queue.

## Operation
- State:
  - `rr_q`: round-robin pointer, $clog2(NumReq) bits.
  - `lock_q`: 1 bit.
  - `sel_q`: the locked requester index.
- Selection:
  - If `lock_q` is 1, the winner is `sel_q`, regardless of other requests.
  - Otherwise the winner is the first `i` with `req_i[i]` set, scanning `rr_q, rr_q+1, …` modulo NumReq. Wrap-around from NumReq-1 to 0.
- Forwarding:
  - `oup_req_o` = 1 when any requester is selected (`req_i` non-zero, or `lock_q` set).
  - `oup_id_o` = `id_i[winner]`.
  - `oup_pop_o` = `pop_i[winner]`.
  - With no winner, `oup_id_o` and `oup_pop_o` are 0.
- Return path:
  - `gnt_o[winner]` = `oup_gnt_i`; all other bits of `gnt_o` are 0.
  - `data_valid_o[winner]` = `oup_gnt_i & oup_data_valid_i`.
  - `data_o` = `oup_data_i`, passed through unconditionally.
- State machine: two states, IDLE (`lock_q`=0) and LOCKED (`lock_q`=1).
  - IDLE → LOCKED when `oup_req_o & ~oup_gnt_i`. `sel_q` captures the winner.
  - LOCKED → IDLE when `oup_gnt_i`.
  - Any state: on `oup_gnt_i`, `rr_q` ← (winner+1) mod NumReq.
  - `rr_q` is unchanged when there is no handshake.
- Requester obligation: while `req_i[i]` is high and ungranted, `id_i[i]` and `pop_i[i]` stay stable and `req_i[i]` does not drop. The block does not check this; behaviour is undefined if it is violated.
- Fairness: with all requesters continuously requesting and the queue granting every cycle, each requester is granted exactly once in every NumReq consecutive grants.

## Timing
- Request path is combinational: `req_i` → `oup_req_o`, zero cycles.
- Grant and data path is combinational: `oup_gnt_i`/`oup_data_*` → `gnt_o`/`data_*`, zero cycles.
- Throughput: one grant per cycle.
- Reset, while `rst_i`=1:
  - Outputs are forced: `oup_req_o`=0, `oup_id_o`=0, `oup_pop_o`=0, `gnt_o`=0, `data_valid_o`=0.
  - Registers after the edge: `rr_q`=0, `lock_q`=0, `sel_q`=0.
  - Reset asserted during LOCKED drops the pending request; arbitration restarts from requester 0.
- A request that is held but ungranted for k cycles keeps the same `oup_id_o`/`oup_pop_o` for all k cycles. A higher-priority request arriving meanwhile does not preempt it.
- When a grant and a new request from the next requester occur in the same cycle, the next requester wins in the following cycle.

## Test plan
All scenarios use NumReq=4, IdWidth=10, `data_t`=`logic[3:0]`, with a real `id_queue` (CAPACITY 8) behind the block unless stated otherwise.

1. **Round-robin order.** Push ID 0x005 with data 0xA, ×4. Requesters 0–3 continuously request a pop of ID 0x005 from reset. → Grants go to 0, 1, 2, 3 in consecutive cycles, receiving data A, A, A, A. The fifth request receives a grant with `data_valid_o`=0.
2. **Wrap-around.** After a grant to requester 3, only requesters 0 and 2 request. → Requester 0 wins, then requester 2, then requester 0.
3. **Lock under stall.** Stub the queue so that `oup_gnt_i`=0 for 3 cycles. Requester 1 requests ID 0x012. Requester 0 raises its request in cycle 2. → `oup_id_o`=0x012 for all 4 cycles. Requester 1 is granted first, requester 0 next.
4. **Read versus pop.** Requester 2 issues `pop_i`=0 on ID 0x3FF, which holds data 0x7, then `pop_i`=1 on the same ID. → Both return 0x7. A third read returns `data_valid_o`=0.
5. **Reset in LOCKED.** Stall requester 3, then pulse `rst_i` for 1 cycle. → `oup_req_o`=0 during reset. `rr_q`=0 afterwards, so requester 0 wins next if it is requesting.
6. **Random soak.** Random requests, IDs, pops and queue stalls for 10000 grants. → Every requester's data is checked against the queue model. No starvation: the wait between a requester's request and its grant is at most NumReq grants.
